// File: rtl/wfg_stim_mem_arb_pkg.sv
// Shared constants for the stimulus SRAM read-port arbiter.
// Address/data defaults, read latency and pointer wrap helper.
package wfg_stim_mem_arb_pkg;

  localparam int DEF_AW = 10;
  localparam int DEF_DW = 32;
  localparam int RD_LAT = 1;

  function automatic int wrap_inc(
    input int v,
    input int n
  );
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/wfg_stim_mem_arb_if.sv
// Requester-side bus of the stimulus SRAM arbiter.
// master = requesters, slave = arbiter.
interface wfg_stim_mem_arb_if
  import wfg_stim_mem_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
);

  logic                 en_i;
  logic [NREQ-1:0]      req_i;
  logic [NREQ*AW-1:0]   addr_i;
  logic [NREQ-1:0]      gnt_o;
  logic [NREQ-1:0]      rvalid_o;
  logic [DW-1:0]        rdata_o;

  modport master (
    output en_i,
    output req_i,
    output addr_i,
    input  gnt_o,
    input  rvalid_o,
    input  rdata_o
  );

  modport slave (
    input  en_i,
    input  req_i,
    input  addr_i,
    output gnt_o,
    output rvalid_o,
    output rdata_o
  );

endinterface

// File: rtl/wfg_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr.
// Purely combinational; returns one-hot grant and its index.
module wfg_rr_pick #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/wfg_stim_mem_arb.sv
// Round-robin arbiter for the stimulus SRAM read port.
// Grants one reader per cycle; data returns one cycle later.
module wfg_stim_mem_arb
  import wfg_stim_mem_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  wfg_stim_mem_arb_if.slave bus,
  output logic          csb1,
  output logic [AW-1:0] addr1,
  input  logic [DW-1:0] dout1
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]   ptr_q;
  logic [NREQ-1:0] req_eff;
  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   idx;
  logic            any;
  logic [NREQ-1:0] vld_q [RD_LAT];

  // Reset is folded in so the macro sees no access while held.
  assign req_eff = (bus.en_i && rst_n) ? bus.req_i : '0;

  wfg_rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_pick (
    .req (req_eff),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );

  assign bus.gnt_o    = gnt;
  assign csb1         = ~any;
  assign addr1        = any ? bus.addr_i[int'(idx)*AW +: AW]
                            : '0;
  assign bus.rvalid_o = vld_q[RD_LAT-1];
  assign bus.rdata_o  = dout1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (any) begin
      ptr_q <= PW'(wrap_inc(int'(idx), NREQ));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < RD_LAT; j++) vld_q[j] <= '0;
    end else begin
      vld_q[0] <= gnt;
      for (int j = 1; j < RD_LAT; j++) vld_q[j] <= vld_q[j-1];
    end
  end

endmodule
